// File: rtl/apb_aes_regfile.sv
// rtl/apb_aes_regfile.sv - AES control/key/data register file behind the APB slave stage
//
// Holds CTRL, STATUS, KEY0-3, DIN0-3, DOUT0-3 and ID. Drives the AES core
// (start_o, mode_o, key_o, din_o), captures its result on aes_done_i and
// returns registered read data, an unmapped-access pulse and an interrupt.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   addr, write_en, read_en  decoded access (one-cycle qualifiers)
//   byte_strobe, wdata       write lanes and data
//   rdata, addr_err          registered read data, unmapped-access pulse
//   key_o, din_o, mode_o     AES key / input block / direction
//   start_o                  one-cycle start pulse
//   aes_busy_i, aes_done_i, aes_dout_i  AES core status and result
//   irq_o                    registered interrupt level
module apb_aes_regfile #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          NBYTES     = DATA_WIDTH / 8,
    parameter logic [31:0] ID_VALUE   = 32'h4145_5331
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [NBYTES-1:0]     byte_strobe,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  addr_err,
    output logic [127:0]          key_o,
    output logic [127:0]          din_o,
    output logic                  mode_o,
    output logic                  start_o,
    input  logic                  aes_busy_i,
    input  logic                  aes_done_i,
    input  logic [127:0]          aes_dout_i,
    output logic                  irq_o
);

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_STATUS = 6'd1;
    localparam logic [5:0] IDX_KEY0   = 6'd2;
    localparam logic [5:0] IDX_DIN0   = 6'd6;
    localparam logic [5:0] IDX_DOUT0  = 6'd10;
    localparam logic [5:0] IDX_ID     = 6'd14;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [3:0][31:0]      key_q, key_d;
    logic [3:0][31:0]      din_q, din_d;
    logic [127:0]          dout_q, dout_d;
    logic                  irq_en_q, irq_en_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  serr_q, serr_d;
    logic                  start_q, start_d;
    logic                  addr_err_q, addr_err_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [5:0]            idx;
    logic                  mapped;
    logic                  wr;
    logic                  start_req;
    logic                  clr_done, clr_ovr, clr_serr;
    logic [5:0]            key_off, din_off, dout_off;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    assign idx      = addr[7:2];
    assign mapped   = (addr[ADDR_WIDTH-1:8] == '0) && (idx <= IDX_ID);
    assign wr       = write_en && mapped;
    assign key_off  = idx - IDX_KEY0;
    assign din_off  = idx - IDX_DIN0;
    assign dout_off = idx - IDX_DOUT0;

    assign start_req = wr && (idx == IDX_CTRL) && byte_strobe[0] && wdata[0];
    assign clr_done  = wr && (idx == IDX_STATUS) && byte_strobe[0] && wdata[0];
    assign clr_ovr   = wr && (idx == IDX_STATUS) && byte_strobe[0] && wdata[2];
    assign clr_serr  = wr && (idx == IDX_STATUS) && byte_strobe[0] && wdata[3];

    always_comb begin
        rd_mux = '0;
        if (idx == IDX_CTRL) begin
            rd_mux = {29'd0, mode_q, irq_en_q, 1'b0};
        end else if (idx == IDX_STATUS) begin
            rd_mux = {28'd0, serr_q, ovr_q, aes_busy_i, done_q};
        end else if (idx < IDX_DIN0) begin
            rd_mux = key_q[key_off[1:0]];
        end else if (idx < IDX_DOUT0) begin
            rd_mux = din_q[din_off[1:0]];
        end else if (idx < IDX_ID) begin
            rd_mux = dout_q[32*dout_off[1:0] +: 32];
        end else begin
            rd_mux = ID_VALUE;
        end
    end

    always_comb begin
        key_d      = key_q;
        din_d      = din_q;
        irq_en_d   = irq_en_q;
        mode_d     = mode_q;
        rdata_d    = rdata_q;
        addr_err_d = (write_en || read_en) && !mapped;
        start_d    = start_req && !aes_busy_i;
        dout_d     = aes_done_i ? aes_dout_i : dout_q;

        // Hardware set takes priority over a same-cycle W1C clear.
        done_d = aes_done_i || (done_q && !clr_done);
        ovr_d  = (aes_done_i && done_q) || (ovr_q && !clr_ovr);
        serr_d = (start_req && aes_busy_i) || (serr_q && !clr_serr);

        irq_d = irq_en_q && (done_q || ovr_q || serr_q);

        if (wr) begin
            if (idx == IDX_CTRL) begin
                if (byte_strobe[0]) begin
                    irq_en_d = wdata[1];
                    mode_d   = wdata[2];
                end
            end else if (idx >= IDX_KEY0 && idx < IDX_DIN0) begin
                key_d[key_off[1:0]] = merge_bytes(key_q[key_off[1:0]], wdata, byte_strobe);
            end else if (idx >= IDX_DIN0 && idx < IDX_DOUT0) begin
                din_d[din_off[1:0]] = merge_bytes(din_q[din_off[1:0]], wdata, byte_strobe);
            end
        end

        // A simultaneous write wins over the read; rdata keeps its value.
        if (read_en && !write_en) begin
            rdata_d = mapped ? rd_mux : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            key_q      <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            irq_en_q   <= 1'b0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            serr_q     <= 1'b0;
            start_q    <= 1'b0;
            addr_err_q <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            key_q      <= key_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            irq_en_q   <= irq_en_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            serr_q     <= serr_d;
            start_q    <= start_d;
            addr_err_q <= addr_err_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign key_o    = key_q;
    assign din_o    = din_q;
    assign mode_o   = mode_q;
    assign start_o  = start_q;
    assign addr_err = addr_err_q;
    assign irq_o    = irq_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_apb_aes_regfile.sv
// tb/tb_apb_aes_regfile.sv - directed scoreboard bench for apb_aes_regfile
module tb_apb_aes_regfile;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic [31:0]  addr = '0;
    logic         write_en = 1'b0;
    logic         read_en = 1'b0;
    logic [3:0]   byte_strobe = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         addr_err;
    logic [127:0] key_o;
    logic [127:0] din_o;
    logic         mode_o;
    logic         start_o;
    logic         aes_busy_i = 1'b0;
    logic         aes_done_i = 1'b0;
    logic [127:0] aes_dout_i = '0;
    logic         irq_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] exp_q[$];
    string        tag_q[$];

    apb_aes_regfile dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .addr        (addr),
        .write_en    (write_en),
        .read_en     (read_en),
        .byte_strobe (byte_strobe),
        .wdata       (wdata),
        .rdata       (rdata),
        .addr_err    (addr_err),
        .key_o       (key_o),
        .din_o       (din_o),
        .mode_o      (mode_o),
        .start_o     (start_o),
        .aes_busy_i  (aes_busy_i),
        .aes_done_i  (aes_done_i),
        .aes_dout_i  (aes_dout_i),
        .irq_o       (irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic push_exp(input string tag, input logic [127:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [127:0] obs);
        logic [127:0] e;
        string        t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %h want <queued entry>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: got %h want %h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] e);
        push_exp(tag, e);
        pop_chk(obs);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byte_strobe = be; write_en = 1'b1;
        step();
        write_en = 1'b0; byte_strobe = '0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] e);
        addr = a; read_en = 1'b1;
        push_exp(tag, {96'd0, e});
        step();
        read_en = 1'b0;
        pop_chk({96'd0, rdata});
    endtask

    task automatic done_pulse(input logic [127:0] d);
        aes_dout_i = d; aes_done_i = 1'b1;
        step();
        aes_done_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rdata", {96'd0, rdata}, 128'd0);
        chk("rst_ctl", {start_o, addr_err, irq_o, mode_o}, 128'd0);
        chk("rst_key", key_o, 128'd0);
        chk("rst_din", din_o, 128'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        step();
        chk("no_start_after_rst", {127'd0, start_o}, 128'd0);

        do_read("id", 32'h38, 32'h4145_5331);
        do_read("status_idle", 32'h04, 32'h0);

        // Partial-strobe key write
        do_write(32'h08, 32'hDEAD_BEEF, 4'b0101);
        chk("key0_strobe", {96'd0, key_o[31:0]}, 128'h00AD_00EF);
        do_read("key0_rd", 32'h08, 32'h00AD_00EF);

        // Start while idle
        do_write(32'h00, 32'h7, 4'hF);
        chk("start_pulse", {127'd0, start_o}, 128'd1);
        chk("mode_set", {127'd0, mode_o}, 128'd1);
        step();
        chk("start_one_cycle", {127'd0, start_o}, 128'd0);

        // Start while busy
        aes_busy_i = 1'b1;
        do_write(32'h00, 32'h3, 4'hF);
        chk("start_busy_nopulse", {127'd0, start_o}, 128'd0);
        do_read("status_serr", 32'h04, 32'hA);
        chk("irq_serr", {127'd0, irq_o}, 128'd1);
        aes_busy_i = 1'b0;
        do_write(32'h04, 32'h8, 4'hF);
        do_read("status_serr_clr", 32'h04, 32'h0);
        chk("irq_clr", {127'd0, irq_o}, 128'd0);

        // AES result capture, overrun, set-wins-over-clear
        done_pulse(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        do_read("dout0", 32'h28, 32'hCCDD_EEFF);
        do_read("dout3", 32'h34, 32'h0011_2233);
        do_read("status_done", 32'h04, 32'h1);
        chk("irq_done", {127'd0, irq_o}, 128'd1);
        done_pulse(128'h1);
        do_read("status_ovr", 32'h04, 32'h5);
        do_read("dout0_ovw", 32'h28, 32'h1);
        aes_done_i = 1'b1; aes_dout_i = 128'h2;
        do_write(32'h04, 32'h1, 4'hF);
        aes_done_i = 1'b0;
        do_read("status_set_wins", 32'h04, 32'h5);
        do_write(32'h04, 32'h5, 4'hF);
        chk("irq_hold_1cyc", {127'd0, irq_o}, 128'd1);
        step();
        chk("irq_drop", {127'd0, irq_o}, 128'd0);

        // Unmapped accesses
        do_read("rd_unmapped", 32'h3C, 32'h0);
        chk("aerr_rd", {127'd0, addr_err}, 128'd1);
        step();
        chk("aerr_pulse_end", {127'd0, addr_err}, 128'd0);
        do_write(32'h100, 32'hFFFF_FFFF, 4'hF);
        chk("aerr_wr", {127'd0, addr_err}, 128'd1);
        chk("unmapped_no_start", {127'd0, start_o}, 128'd0);
        do_read("ctrl_unchanged", 32'h00, 32'h2);
        chk("key_unchanged", {96'd0, key_o[31:0]}, 128'h00AD_00EF);

        // Write and read together: write wins, rdata held
        addr = 32'h18; wdata = 32'h1234_5678; byte_strobe = 4'hF;
        write_en = 1'b1; read_en = 1'b1;
        step();
        write_en = 1'b0; read_en = 1'b0;
        chk("wr_rd_rdata_held", {96'd0, rdata}, 128'h2);
        chk("wr_rd_din", {96'd0, din_o[31:0]}, 128'h1234_5678);
        chk("wr_rd_no_aerr", {127'd0, addr_err}, 128'd0);

        // Asynchronous reset mid-sequence
        do_write(32'h00, 32'h7, 4'hF);
        chk("start_before_rst", {127'd0, start_o}, 128'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_rst_ctl", {start_o, addr_err, irq_o, mode_o}, 128'd0);
        chk("async_rst_rdata", {96'd0, rdata}, 128'd0);
        chk("async_rst_din", din_o, 128'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        step();
        chk("no_start_after_rst2", {127'd0, start_o}, 128'd0);
        do_read("status_after_rst", 32'h04, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
